mandelbrot_config_loader: RTL and testbench

Serial configuration front-end for the mandelbrot core. It is the parametrised successor of the fixed 24-bit config shift chain.
- Shifts in a framed word holding scaling, ci/cr offsets and max iteration count, plus an even-parity bit.
- Validates frame length and parity on commit.
- Applies the new config atomically, and only while the core is idle.
- Supports readback of the active config through the same chain.

---
 rtl/mandelbrot_pkg.sv | 24 ++
 rtl/mandelbrot_config_loader.sv | 101 ++++++++++
 tb/tb_mandelbrot_config_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared widths, frame layout constants and loader state for the mandelbrot config path
package mandelbrot_pkg;

    localparam int DEF_BITWIDTH = 11;
    localparam int DEF_CTRWIDTH = 7;
    localparam int DEF_SCALE_W  = 2;

    localparam int DEF_CFG_W   = DEF_SCALE_W + 2*DEF_BITWIDTH + DEF_CTRWIDTH;
    localparam int DEF_FRAME_W = DEF_CFG_W + 1;

    // Field LSB positions inside the CFG_W-bit config word (parity bit excluded)
    localparam int DEF_MAX_CTR_LSB = 0;
    localparam int DEF_CR_LSB      = DEF_CTRWIDTH;
    localparam int DEF_CI_LSB      = DEF_CTRWIDTH + DEF_BITWIDTH;
    localparam int DEF_SCALE_LSB   = DEF_CTRWIDTH + 2*DEF_BITWIDTH;

    localparam logic [DEF_CTRWIDTH-1:0] DEF_MAX_CTR_RST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } loader_state_t;

endpackage

// File: rtl/mandelbrot_config_loader.sv
// rtl/mandelbrot_config_loader.sv - serial config shift chain with length/parity validation and idle-gated apply
module mandelbrot_config_loader
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int CTRWIDTH = DEF_CTRWIDTH,
    parameter int SCALE_W  = DEF_SCALE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic                shift_in,
    input  logic                capture,
    input  logic                commit,
    input  logic                core_busy,
    output logic                shift_out,
    output logic [SCALE_W-1:0]  cfg_scaling,
    output logic [BITWIDTH-1:0] cfg_ci_offset,
    output logic [BITWIDTH-1:0] cfg_cr_offset,
    output logic [CTRWIDTH-1:0] cfg_max_ctr,
    output logic                cfg_valid,
    output logic                cfg_pending,
    output logic                err_length,
    output logic                err_parity
);

    localparam int CFG_W     = SCALE_W + 2*BITWIDTH + CTRWIDTH;
    localparam int FRAME_W   = CFG_W + 1;
    localparam int CNT_W     = $clog2(FRAME_W + 2);
    localparam int CR_LSB    = CTRWIDTH;
    localparam int CI_LSB    = CTRWIDTH + BITWIDTH;
    localparam int SCALE_LSB = CTRWIDTH + 2*BITWIDTH;

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] OVER_CNT  = CNT_W'(FRAME_W + 1);

    logic [CFG_W:0]     sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CFG_W-1:0]   staging;
    loader_state_t      state;

    logic [CFG_W-1:0]   active;
    logic               len_bad;
    logic               par_bad;
    logic               frame_ok;

    assign active   = {cfg_scaling, cfg_ci_offset, cfg_cr_offset, cfg_max_ctr};
    assign len_bad  = (bit_cnt != FRAME_CNT);
    assign par_bad  = ^sr;
    assign frame_ok = !len_bad && !par_bad;

    assign shift_out   = sr[CFG_W];
    assign cfg_pending = (state == ST_PENDING);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr            <= '0;
            bit_cnt       <= '0;
            staging       <= '0;
            state         <= ST_IDLE;
            cfg_scaling   <= '0;
            cfg_ci_offset <= '0;
            cfg_cr_offset <= '0;
            cfg_max_ctr   <= '1;
            cfg_valid     <= 1'b0;
            err_length    <= 1'b0;
            err_parity    <= 1'b0;
        end else begin
            // Shift-chain side: capture beats commit beats shift
            if (capture) begin
                sr      <= {active, ^active};
                bit_cnt <= FRAME_CNT;
            end else if (commit) begin
                bit_cnt    <= '0;
                err_length <= len_bad;
                err_parity <= par_bad;
                if (frame_ok) begin
                    staging <= sr[CFG_W:1];
                end
            end else if (shift_en) begin
                sr <= {sr[CFG_W-1:0], shift_in};
                if (bit_cnt != OVER_CNT) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            // A fresh valid commit defers any apply so the newest staging is the one applied
            if (!capture && commit && frame_ok) begin
                state <= ST_PENDING;
            end else if (state == ST_PENDING && !core_busy) begin
                cfg_scaling   <= staging[SCALE_LSB +: SCALE_W];
                cfg_ci_offset <= staging[CI_LSB +: BITWIDTH];
                cfg_cr_offset <= staging[CR_LSB +: BITWIDTH];
                cfg_max_ctr   <= staging[0 +: CTRWIDTH];
                cfg_valid     <= 1'b1;
                state         <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_config_loader.sv
// tb/tb_mandelbrot_config_loader.sv - directed-vector bench for mandelbrot_config_loader
module tb_mandelbrot_config_loader;

    logic        clk = 1'b0;
    logic        reset, shift_en, shift_in, capture, commit, core_busy;
    logic        shift_out;
    logic [1:0]  cfg_scaling;
    logic [10:0] cfg_ci_offset, cfg_cr_offset;
    logic [6:0]  cfg_max_ctr;
    logic        cfg_valid, cfg_pending, err_length, err_parity;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed frames: fields MSB-first, then even-parity bit
    // A: popcount 1+5+5+1 = 12 -> parity 0
    localparam logic [31:0] FRAME_A = {2'b10, 11'h155, 11'h2AA, 7'h40, 1'b0};
    // B: popcount 1+4+4+3 = 12 -> parity 0
    localparam logic [31:0] FRAME_B = {2'b01, 11'h0F0, 11'h00F, 7'h15, 1'b0};
    // C: popcount 2+1+1+6 = 10 -> parity 0
    localparam logic [31:0] FRAME_C = {2'b11, 11'h001, 11'h400, 7'h7E, 1'b0};

    mandelbrot_config_loader dut (
        .clk           (clk),
        .reset         (reset),
        .shift_en      (shift_en),
        .shift_in      (shift_in),
        .capture       (capture),
        .commit        (commit),
        .core_busy     (core_busy),
        .shift_out     (shift_out),
        .cfg_scaling   (cfg_scaling),
        .cfg_ci_offset (cfg_ci_offset),
        .cfg_cr_offset (cfg_cr_offset),
        .cfg_max_ctr   (cfg_max_ctr),
        .cfg_valid     (cfg_valid),
        .cfg_pending   (cfg_pending),
        .err_length    (err_length),
        .err_parity    (err_parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            shift_en = 1'b1;
            shift_in = f[31-i];
            tick();
        end
        shift_en = 1'b0;
        shift_in = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic check_cfg(input string tag, input logic [31:0] f);
        check({tag, "_cfg"}, {cfg_scaling, cfg_ci_offset, cfg_cr_offset, cfg_max_ctr, 1'b0},
              {f[31:1], 1'b0});
    endtask

    logic [31:0] rb;

    initial begin
        reset = 1'b1; shift_en = 1'b0; shift_in = 1'b0;
        capture = 1'b0; commit = 1'b0; core_busy = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_max_ctr", cfg_max_ctr, 32'h7F);
        check("rst_fields", {cfg_scaling, cfg_ci_offset, cfg_cr_offset}, 32'h0);
        check("rst_flags", {cfg_valid, cfg_pending, err_length, err_parity, shift_out}, 32'h0);

        // Basic apply of frame A
        shift_bits(FRAME_A, 32);
        do_commit();
        check("a_pending", cfg_pending, 32'h1);
        check("a_not_yet", cfg_max_ctr, 32'h7F);
        tick();
        check("a_pending_clr", cfg_pending, 32'h0);
        check_cfg("a", FRAME_A);
        check("a_flags", {cfg_valid, err_length, err_parity}, 32'b100);

        // Short frame -> length error, nothing staged
        shift_bits(FRAME_B, 31);
        do_commit();
        check("short_err", {err_length, err_parity, cfg_pending}, 32'b100);
        tick();
        check_cfg("short_keep", FRAME_A);
        shift_bits(FRAME_B, 32);
        do_commit();
        check("b_err_clr", {err_length, err_parity, cfg_pending}, 32'b001);
        tick();
        check_cfg("b", FRAME_B);

        // Parity flip -> parity error only
        shift_bits(FRAME_C ^ 32'h1, 32);
        do_commit();
        check("par_err", {err_length, err_parity, cfg_pending}, 32'b010);
        tick();
        check_cfg("par_keep", FRAME_B);

        // Busy core: A then C committed, newest wins after release
        core_busy = 1'b1;
        shift_bits(FRAME_A, 32);
        do_commit();
        shift_bits(FRAME_C, 32);
        do_commit();
        for (int i = 0; i < 20; i++) tick();
        check("busy_pending", cfg_pending, 32'h1);
        check_cfg("busy_hold", FRAME_B);
        core_busy = 1'b0;
        tick();
        check_cfg("newest", FRAME_C);
        check("newest_flags", {cfg_pending, cfg_valid}, 32'b01);

        // Readback of the active config
        capture = 1'b1;
        tick();
        capture = 1'b0;
        rb = '0;
        for (int i = 0; i < 32; i++) begin
            rb[31-i] = shift_out;
            shift_en = 1'b1;
            shift_in = 1'b0;
            tick();
        end
        shift_en = 1'b0;
        check("readback", rb, FRAME_C);

        // Capture then immediate commit reapplies with no error
        capture = 1'b1;
        tick();
        capture = 1'b0;
        do_commit();
        check("recommit", {cfg_pending, err_length, err_parity}, 32'b100);
        tick();
        check_cfg("recommit", FRAME_C);

        // Capture, commit and shift in the same cycle: only capture acts
        shift_bits(32'hFFFF_FFFF, 5);
        capture = 1'b1; commit = 1'b1; shift_en = 1'b1; shift_in = 1'b0;
        tick();
        capture = 1'b0; commit = 1'b0; shift_en = 1'b0;
        check("prio_no_commit", {cfg_pending, err_length, err_parity}, 32'b000);
        check("prio_msb", shift_out, {31'b0, FRAME_C[31]});
        core_busy = 1'b1;
        do_commit();
        check("prio_cnt_full", {cfg_pending, err_length, err_parity}, 32'b100);

        // Reset while pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_busy = 1'b0;
        check("rst2_flags", {cfg_valid, cfg_pending, err_length, err_parity, shift_out}, 32'h0);
        check("rst2_fields", {cfg_scaling, cfg_ci_offset, cfg_cr_offset, cfg_max_ctr}, 32'h7F);
        tick();
        check("rst2_no_apply", {cfg_valid, cfg_max_ctr}, 32'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
